nibble_shift_capture: RTL and testbench
=======================================

// Module: nibble_shift_capture
// PURPOSE
//  Upstream input stage for the 4-bit parity/even-odd display. The operator
//  enters a nibble one bit at a time: set a slide switch, then press a pushbutton.
//  Switch and button are synchronised and the button is debounced. The bits are
//  shifted in and the completed word is offered to the downstream stage over a
//  valid/ready handshake.
// PARAMETERS
//  WIDTH            4       bits per captured word (2..7)
//  DEBOUNCE_CYCLES  500000  consecutive stable clk cycles to accept a button level
//                           (10 ms @ 50 MHz); minimum 1
// PORTS
//  clk           in   1      board clock; all logic on rising edge
//  rst           in   1      synchronous reset, active-high
//  key_n         in   1      raw pushbutton, active-low, asynchronous, bouncy
//  sw_bit        in   1      raw data switch, asynchronous
//  nibble_o      out  WIDTH  captured word, MSB = first bit entered
//  nibble_valid  out  1      nibble_o holds a complete word not yet taken
//  nibble_ready  in   1      downstream accepts the word when high with nibble_valid
//  bit_count     out  3      bits collected so far (0..WIDTH-1); drives LEDs
//  busy          out  1      high while 0 < bit_count < WIDTH
// BEHAVIOUR
//  Reset (rst=1 at clk edge) overrides everything:
//   - state=COLLECT; shift reg, nibble_o, bit_count = 0
//   - nibble_valid=0, busy=0
//   - debounced key = 1 (released); debounce counter = 0; sync flops = 1
//  Synchronise:
//   - key_n and sw_bit each pass through 2 flops before any use
//  Debounce:
//   - counter clears when synced key equals the debounced level
//   - otherwise the counter increments
//   - when it reaches DEBOUNCE_CYCLES-1 and key still differs, the debounced
//     level toggles and the counter clears
//   - glitches shorter than DEBOUNCE_CYCLES cycles never change the level
//  Press event:
//   - one-cycle pulse on a debounced 1->0 transition
//   - the release transition generates nothing
//  FSM, 2 states:
//   - COLLECT: on press, shift <= {shift[WIDTH-2:0], sw_sync}; bit_count++
//     - the WIDTH-th press loads nibble_o with the completed word
//     - nibble_valid <= 1; bit_count <= 0; go to HOLD
//     - latency: nibble_valid rises on the clk edge after the final press pulse
//   - HOLD: nibble_o and nibble_valid stay stable until nibble_valid & nibble_ready
//     - on that edge: nibble_valid <= 0; go to COLLECT
//     - nibble_o retains its value so the display keeps showing it
//  Boundaries:
//   - press during HOLD is discarded, including in the handshake cycle
//   - nibble_ready while not valid has no effect
//   - rst mid-collection discards partial bits
//   - bit_count never exceeds WIDTH-1; sw_bit changes between presses are ignored
// CONFIGURATION
//  OVERRUN_FLAG_EN defined:
//   - adds output port `overrun` (1 bit, reset 0)
//   - a press discarded in HOLD sets it sticky
//   - cleared only by rst
//  OVERRUN_FLAG_EN undefined:
//   - no overrun port; discarded presses are silent
//   - all other behaviour identical
// TESTING  (DEBOUNCE_CYCLES=4, WIDTH=4)
//  1 reset
//    rst=1 for 2 clk -> nibble_o=0, nibble_valid=0, bit_count=0, busy=0
//  2 bounce rejection
//    key_n low 3 cycles, then high -> no press, bit_count stays 0
//  3 capture
//    sw=1,0,1,1 each with a clean press (low 10 cycles)
//    -> nibble_o=4'b1011, nibble_valid=1, bit_count=0
//  4 handshake
//    ready=0 for 20 cycles -> valid/nibble stable
//    ready=1 one cycle -> valid=0 next edge, nibble_o still 4'b1011
//  5 reset mid-operation
//    2 presses (sw=1,1), rst pulse, 4 presses sw=0,1,1,0 -> nibble_o=4'b0110
//  6 overrun (macro on)
//    press while in HOLD -> overrun=1, nibble unchanged; rst clears it
//    macro off -> same press, no effect

Source files
------------

// File: rtl/nibble_shift_capture.sv
// Bit-serial nibble entry: synchronised switch + debounced pushbutton shift bits into a word
// offered over valid/ready. Define OVERRUN_FLAG_EN to add a sticky `overrun` output.
module nibble_shift_capture #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_n,
    input  logic             sw_bit,
    output logic [WIDTH-1:0] nibble_o,
    output logic             nibble_valid,
    input  logic             nibble_ready,
    output logic [2:0]       bit_count,
`ifdef OVERRUN_FLAG_EN
    output logic             overrun,
`endif
    output logic             busy
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0]    LAST_BIT = 3'(WIDTH - 1);

    typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

    logic          key_s1_q, key_s2_q, sw_s1_q, sw_s2_q;
    logic          key_db_q, key_db_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] nibble_q, nibble_d;
    logic             valid_q, valid_d;
    logic [2:0]       bits_q, bits_d;
`ifdef OVERRUN_FLAG_EN
    logic             overrun_q, overrun_d;
`endif

    // Debounce: the level only flips after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        key_db_d = key_db_q;
        cnt_d    = '0;
        press_d  = 1'b0;
        if (key_s2_q != key_db_q) begin
            if (cnt_q == CNT_MAX) begin
                key_db_d = ~key_db_q;
                press_d  = key_db_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        nibble_d = nibble_q;
        valid_d  = valid_q;
        bits_d   = bits_q;
`ifdef OVERRUN_FLAG_EN
        overrun_d = overrun_q;
`endif
        case (state_q)
            COLLECT: begin
                if (press_q) begin
                    shift_d = {shift_q[WIDTH-2:0], sw_s2_q};
                    if (bits_q == LAST_BIT) begin
                        nibble_d = shift_d;
                        shift_d  = '0;
                        valid_d  = 1'b1;
                        bits_d   = 3'd0;
                        state_d  = HOLD;
                    end else begin
                        bits_d = bits_q + 3'd1;
                    end
                end
            end
            HOLD: begin
                if (valid_q && nibble_ready) begin
                    valid_d = 1'b0;
                    state_d = COLLECT;
                end
`ifdef OVERRUN_FLAG_EN
                if (press_q) overrun_d = 1'b1;
`endif
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_s1_q <= 1'b1;
            key_s2_q <= 1'b1;
            sw_s1_q  <= 1'b1;
            sw_s2_q  <= 1'b1;
            key_db_q <= 1'b1;
            cnt_q    <= '0;
            press_q  <= 1'b0;
            state_q  <= COLLECT;
            shift_q  <= '0;
            nibble_q <= '0;
            valid_q  <= 1'b0;
            bits_q   <= 3'd0;
`ifdef OVERRUN_FLAG_EN
            overrun_q <= 1'b0;
`endif
        end else begin
            key_s1_q <= key_n;
            key_s2_q <= key_s1_q;
            sw_s1_q  <= sw_bit;
            sw_s2_q  <= sw_s1_q;
            key_db_q <= key_db_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
            state_q  <= state_d;
            shift_q  <= shift_d;
            nibble_q <= nibble_d;
            valid_q  <= valid_d;
            bits_q   <= bits_d;
`ifdef OVERRUN_FLAG_EN
            overrun_q <= overrun_d;
`endif
        end
    end

    assign nibble_o     = nibble_q;
    assign nibble_valid = valid_q;
    assign bit_count    = bits_q;
    assign busy         = (bits_q != 3'd0);
`ifdef OVERRUN_FLAG_EN
    assign overrun      = overrun_q;
`endif

endmodule

// File: tb/tb_nibble_shift_capture.sv
// Directed bench for nibble_shift_capture with WIDTH=4, DEBOUNCE_CYCLES=4.
// Checks the overrun output when OVERRUN_FLAG_EN is defined.
module tb_nibble_shift_capture;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       key_n = 1'b1;
    logic       sw_bit = 1'b0;
    logic [3:0] nibble_o;
    logic       nibble_valid;
    logic       nibble_ready = 1'b0;
    logic [2:0] bit_count;
    logic       busy;
`ifdef OVERRUN_FLAG_EN
    logic       overrun;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nibble_shift_capture #(.WIDTH(4), .DEBOUNCE_CYCLES(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .key_n        (key_n),
        .sw_bit       (sw_bit),
        .nibble_o     (nibble_o),
        .nibble_valid (nibble_valid),
        .nibble_ready (nibble_ready),
        .bit_count    (bit_count),
`ifdef OVERRUN_FLAG_EN
        .overrun      (overrun),
`endif
        .busy         (busy)
    );

    typedef struct {
        logic       sw;
        logic [3:0] exp_nibble;
        logic       exp_valid;
        logic [2:0] exp_count;
        logic       exp_busy;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        cycles(1);
    endtask

    task automatic press(input logic sw, input int low_cycles);
        sw_bit = sw;
        cycles(2);
        key_n = 1'b0;
        cycles(low_cycles);
        key_n = 1'b1;
        cycles(12);
    endtask

    task automatic run_vec(input int i);
        press(vecs[i].sw, 10);
        check($sformatf("vec%0d nibble", i), nibble_o, vecs[i].exp_nibble);
        check($sformatf("vec%0d valid", i), nibble_valid, vecs[i].exp_valid);
        check($sformatf("vec%0d count", i), bit_count, vecs[i].exp_count);
        check($sformatf("vec%0d busy", i), busy, vecs[i].exp_busy);
    endtask

    initial begin
        int unstable;
        vecs[0] = '{1'b1, 4'b0000, 1'b0, 3'd1, 1'b1};
        vecs[1] = '{1'b0, 4'b0000, 1'b0, 3'd2, 1'b1};
        vecs[2] = '{1'b1, 4'b0000, 1'b0, 3'd3, 1'b1};
        vecs[3] = '{1'b1, 4'b1011, 1'b1, 3'd0, 1'b0};
        vecs[4] = '{1'b0, 4'b0000, 1'b0, 3'd1, 1'b1};
        vecs[5] = '{1'b1, 4'b0000, 1'b0, 3'd2, 1'b1};
        vecs[6] = '{1'b1, 4'b0000, 1'b0, 3'd3, 1'b1};
        vecs[7] = '{1'b0, 4'b0110, 1'b1, 3'd0, 1'b0};

        cycles(1);
        do_reset();
        check("reset nibble", nibble_o, 0);
        check("reset valid", nibble_valid, 0);
        check("reset count", bit_count, 0);
        check("reset busy", busy, 0);
`ifdef OVERRUN_FLAG_EN
        check("reset overrun", overrun, 0);
`endif

        // Bounce shorter than the debounce window must not register.
        press(1'b1, 3);
        check("bounce count", bit_count, 0);
        check("bounce busy", busy, 0);

        // Exactly DEBOUNCE_CYCLES low is the shortest accepted press.
        press(1'b1, 4);
        check("min press count", bit_count, 1);
        do_reset();
        check("post reset count", bit_count, 0);

        for (int i = 0; i < 4; i++) run_vec(i);

        nibble_ready = 1'b0;
        unstable = 0;
        for (int c = 0; c < 20; c++) begin
            cycles(1);
            if (nibble_valid !== 1'b1 || nibble_o !== 4'b1011) unstable++;
        end
        check("hold stable", unstable, 0);

        nibble_ready = 1'b1;
        cycles(1);
        nibble_ready = 1'b0;
        check("ack valid", nibble_valid, 0);
        check("ack nibble", nibble_o, 4'b1011);

        nibble_ready = 1'b1;
        cycles(3);
        nibble_ready = 1'b0;
        check("idle ready valid", nibble_valid, 0);
        check("idle ready count", bit_count, 0);

        press(1'b1, 10);
        press(1'b1, 10);
        check("partial count", bit_count, 2);
        check("partial nibble kept", nibble_o, 4'b1011);
        do_reset();
        check("midrst nibble", nibble_o, 0);
        check("midrst count", bit_count, 0);
        check("midrst busy", busy, 0);

        for (int i = 4; i < 8; i++) run_vec(i);

        // Press while holding a word is discarded.
        press(1'b1, 10);
        check("hold press nibble", nibble_o, 4'b0110);
        check("hold press valid", nibble_valid, 1);
        check("hold press count", bit_count, 0);
`ifdef OVERRUN_FLAG_EN
        check("overrun set", overrun, 1);
        nibble_ready = 1'b1;
        cycles(1);
        nibble_ready = 1'b0;
        check("overrun sticky", overrun, 1);
        do_reset();
        check("overrun cleared", overrun, 0);
`else
        nibble_ready = 1'b1;
        cycles(1);
        nibble_ready = 1'b0;
        check("post hold ack valid", nibble_valid, 0);
        press(1'b0, 10);
        check("post hold count", bit_count, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
